// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared encodings for the jump-redirect controller: mux selects, redirect source, FSM state.
// The optional delay-slot flush policy is selected with JUMP_REDIRECT_DELAY_SLOT_EN.
package jump_redirect_ctrl_pkg;

    localparam int PC_BUS_W       = 16;
    localparam int JUMP_DATA_BUS_W = 2;

    localparam logic [JUMP_DATA_BUS_W-1:0] JUMP_DATA_NOP  = 2'b00;
    localparam logic [JUMP_DATA_BUS_W-1:0] JUMP_DATA_ALU  = 2'b01;
    localparam logic [JUMP_DATA_BUS_W-1:0] JUMP_DATA_JANS = 2'b10;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ID   = 2'b01,
        SRC_EX   = 2'b10
    } src_t;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    // Only an EX-resolved branch has a wrong-path instruction sitting in ID.
    function automatic logic src_kills_id(input src_t src);
        return (src == SRC_EX);
    endfunction

endpackage

// File: rtl/jump_redirect_ctrl.sv
// Picks the winning EX/ID redirect, steers the jump-data mux, holds the target for the PC stage
// and pulses the pipeline flushes on consume. Define JUMP_REDIRECT_DELAY_SLOT_EN for delay-slot flushing.
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int PC_W = PC_BUS_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_jump_req,
    input  logic                       id_jump_req,
    input  logic [PC_W-1:0]            jump_addr,
    input  logic                       pc_stall,
`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
    input  logic                       id_is_delay_slot,
`endif
    output logic [JUMP_DATA_BUS_W-1:0] jump_data_op,
    output logic                       redirect_valid,
    output logic [PC_W-1:0]            redirect_addr,
    output logic                       flush_if,
    output logic                       flush_id,
    output logic                       busy
);

    state_t            state_reg;
    src_t              src_reg;
    logic              redirect_valid_reg;
    logic [PC_W-1:0]   redirect_addr_reg;
    logic              flush_if_reg;
    logic              flush_id_reg;

    logic              accept_ex;
    logic              accept_id;
    logic              consume;
    logic              flush_if_next;
    logic              flush_id_next;

    // An EX branch may displace a held ID jump only while the PC stage is stalling;
    // in the consume cycle every request belongs to the wrong path.
    always_comb begin
        accept_ex = 1'b0;
        accept_id = 1'b0;
        consume   = 1'b0;
        if (state_reg == IDLE) begin
            accept_ex = ex_jump_req;
            accept_id = id_jump_req && !ex_jump_req;
        end else begin
            consume   = !pc_stall;
            accept_ex = ex_jump_req && pc_stall && (src_reg == SRC_ID);
        end
    end

    always_comb begin
        jump_data_op = JUMP_DATA_NOP;
        if (accept_ex) begin
            jump_data_op = JUMP_DATA_ALU;
        end else if (accept_id) begin
            jump_data_op = JUMP_DATA_JANS;
        end
    end

    always_comb begin
`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
        flush_if_next = 1'b0;
        flush_id_next = src_kills_id(src_reg) && !id_is_delay_slot;
`else
        flush_if_next = 1'b1;
        flush_id_next = src_kills_id(src_reg);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            src_reg            <= SRC_NONE;
            redirect_valid_reg <= 1'b0;
            redirect_addr_reg  <= '0;
            flush_if_reg       <= 1'b0;
            flush_id_reg       <= 1'b0;
        end else begin
            flush_if_reg <= 1'b0;
            flush_id_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (accept_ex || accept_id) begin
                    state_reg          <= REDIR;
                    redirect_valid_reg <= 1'b1;
                    redirect_addr_reg  <= jump_addr;
                    src_reg            <= accept_ex ? SRC_EX : SRC_ID;
                end
            end else if (consume) begin
                state_reg          <= IDLE;
                redirect_valid_reg <= 1'b0;
                src_reg            <= SRC_NONE;
                flush_if_reg       <= flush_if_next;
                flush_id_reg       <= flush_id_next;
            end else if (accept_ex) begin
                redirect_addr_reg <= jump_addr;
                src_reg           <= SRC_EX;
            end
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_addr  = redirect_addr_reg;
    assign flush_if       = flush_if_reg;
    assign flush_id       = flush_id_reg;
    assign busy           = redirect_valid_reg;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed self-checking bench for jump_redirect_ctrl; also covers the delay-slot build when
// JUMP_REDIRECT_DELAY_SLOT_EN is defined.
module tb_jump_redirect_ctrl;
    import jump_redirect_ctrl_pkg::*;

`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
    localparam logic EXP_FIF = 1'b0;
`else
    localparam logic EXP_FIF = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_req;
    logic        id_jump_req;
    logic [15:0] jump_addr;
    logic        pc_stall;
    logic        id_is_delay_slot;
    logic [1:0]  jump_data_op;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        flush_if;
    logic        flush_id;
    logic        busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    jump_redirect_ctrl #(.PC_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_jump_req    (ex_jump_req),
        .id_jump_req    (id_jump_req),
        .jump_addr      (jump_addr),
        .pc_stall       (pc_stall),
`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
        .id_is_delay_slot(id_is_delay_slot),
`endif
        .jump_data_op   (jump_data_op),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_jump_req = 0; id_jump_req = 0; jump_addr = '0; pc_stall = 0; id_is_delay_slot = 0;
        tick(); tick();
        assert_cnt++; if (redirect_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid: got %0b exp 0", redirect_valid); end
        assert_cnt++; if (redirect_addr !== 16'h0000) begin fail_cnt++; $display("FAIL rst_addr: got %h exp 0000", redirect_addr); end
        assert_cnt++; if ({flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL rst_flush: got %b exp 00", {flush_if, flush_id}); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            assert_cnt++;
            if ({jump_data_op, redirect_valid, flush_if, flush_id, busy} !== 6'b000000) begin
                fail_cnt++;
                $display("FAIL idle_%0d: got op=%b v=%b fif=%b fid=%b busy=%b exp all 0", i, jump_data_op, redirect_valid, flush_if, flush_id, busy);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_id_jump();
        id_jump_req = 1; jump_addr = 16'h0040; pc_stall = 0; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_JANS) begin fail_cnt++; $display("FAIL id_op: got %b exp 10", jump_data_op); end
        tick(); id_jump_req = 0; jump_addr = 16'hFFFF; #1;
        assert_cnt++; if (redirect_valid !== 1'b1 || busy !== 1'b1) begin fail_cnt++; $display("FAIL id_valid: got v=%b busy=%b exp 1", redirect_valid, busy); end
        assert_cnt++; if (redirect_addr !== 16'h0040) begin fail_cnt++; $display("FAIL id_addr: got %h exp 0040", redirect_addr); end
        assert_cnt++; if (jump_data_op !== JUMP_DATA_NOP) begin fail_cnt++; $display("FAIL id_hold_op: got %b exp 00", jump_data_op); end
        tick();
        assert_cnt++; if (flush_if !== EXP_FIF || flush_id !== 1'b0) begin fail_cnt++; $display("FAIL id_flush: got fif=%b fid=%b exp fif=%b fid=0", flush_if, flush_id, EXP_FIF); end
        assert_cnt++; if (redirect_valid !== 1'b0) begin fail_cnt++; $display("FAIL id_consumed: got %b exp 0", redirect_valid); end
        tick();
        assert_cnt++; if ({flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL id_pulse_len: got %b exp 00", {flush_if, flush_id}); end
        $display("test_id_jump: done");
    endtask

    task automatic test_ex_priority();
        ex_jump_req = 1; id_jump_req = 1; jump_addr = 16'h1234; pc_stall = 0; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_ALU) begin fail_cnt++; $display("FAIL pri_op: got %b exp 01", jump_data_op); end
        tick(); ex_jump_req = 0; id_jump_req = 0; jump_addr = 16'h0000; #1;
        assert_cnt++; if (redirect_valid !== 1'b1 || redirect_addr !== 16'h1234) begin fail_cnt++; $display("FAIL pri_addr: got v=%b a=%h exp v=1 a=1234", redirect_valid, redirect_addr); end
        tick();
        assert_cnt++; if (flush_if !== EXP_FIF || flush_id !== 1'b1) begin fail_cnt++; $display("FAIL pri_flush: got fif=%b fid=%b exp fif=%b fid=1", flush_if, flush_id, EXP_FIF); end
        tick();
        $display("test_ex_priority: done");
    endtask

    task automatic test_stall_override();
        id_jump_req = 1; jump_addr = 16'h0040; pc_stall = 1; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_JANS) begin fail_cnt++; $display("FAIL ovr_id_op: got %b exp 10", jump_data_op); end
        tick();
        for (int i = 0; i < 3; i++) begin
            id_jump_req = 1; jump_addr = 16'hBEEF; #1;
            assert_cnt++;
            if (redirect_valid !== 1'b1 || redirect_addr !== 16'h0040 || jump_data_op !== JUMP_DATA_NOP) begin
                fail_cnt++;
                $display("FAIL stall_hold_%0d: got v=%b a=%h op=%b exp v=1 a=0040 op=00", i, redirect_valid, redirect_addr, jump_data_op);
            end
            tick();
        end
        id_jump_req = 0; ex_jump_req = 1; jump_addr = 16'h0100; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_ALU) begin fail_cnt++; $display("FAIL ovr_op: got %b exp 01", jump_data_op); end
        tick(); jump_addr = 16'h0200; #1;
        assert_cnt++; if (redirect_addr !== 16'h0100 || redirect_valid !== 1'b1) begin fail_cnt++; $display("FAIL ovr_addr: got v=%b a=%h exp v=1 a=0100", redirect_valid, redirect_addr); end
        assert_cnt++; if (jump_data_op !== JUMP_DATA_NOP) begin fail_cnt++; $display("FAIL ovr_ex_ignored: got %b exp 00", jump_data_op); end
        tick(); ex_jump_req = 0; pc_stall = 0; #1;
        assert_cnt++; if (redirect_addr !== 16'h0100) begin fail_cnt++; $display("FAIL ovr_keep: got %h exp 0100", redirect_addr); end
        tick();
        assert_cnt++; if (flush_if !== EXP_FIF || flush_id !== 1'b1 || redirect_valid !== 1'b0) begin fail_cnt++; $display("FAIL ovr_flush: got fif=%b fid=%b v=%b exp fif=%b fid=1 v=0", flush_if, flush_id, redirect_valid, EXP_FIF); end
        tick();
        $display("test_stall_override: done");
    endtask

    task automatic test_back_to_back();
        id_jump_req = 1; jump_addr = 16'h0300; pc_stall = 0;
        tick(); ex_jump_req = 1; id_jump_req = 1; jump_addr = 16'h0400; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_NOP) begin fail_cnt++; $display("FAIL drop_op: got %b exp 00", jump_data_op); end
        tick(); ex_jump_req = 0; id_jump_req = 0; #1;
        assert_cnt++; if (redirect_valid !== 1'b0 || flush_if !== EXP_FIF || flush_id !== 1'b0) begin fail_cnt++; $display("FAIL drop_state: got v=%b fif=%b fid=%b exp v=0 fif=%b fid=0", redirect_valid, flush_if, flush_id, EXP_FIF); end
        ex_jump_req = 1; jump_addr = 16'h0500; #1;
        assert_cnt++; if (jump_data_op !== JUMP_DATA_ALU) begin fail_cnt++; $display("FAIL b2b_op: got %b exp 01", jump_data_op); end
        tick(); ex_jump_req = 0; #1;
        assert_cnt++; if (redirect_valid !== 1'b1 || redirect_addr !== 16'h0500 || flush_if !== 1'b0) begin fail_cnt++; $display("FAIL b2b_addr: got v=%b a=%h fif=%b exp v=1 a=0500 fif=0", redirect_valid, redirect_addr, flush_if); end
        tick(); tick();
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid_redir();
        ex_jump_req = 1; jump_addr = 16'h0700; pc_stall = 1;
        tick(); ex_jump_req = 0; #1;
        assert_cnt++; if (redirect_valid !== 1'b1) begin fail_cnt++; $display("FAIL rmid_setup: got %b exp 1", redirect_valid); end
        rst = 1;
        tick(); rst = 0; pc_stall = 0; #1;
        assert_cnt++; if (redirect_valid !== 1'b0 || redirect_addr !== 16'h0000 || {flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL rmid_clear: got v=%b a=%h fl=%b exp 0/0000/00", redirect_valid, redirect_addr, {flush_if, flush_id}); end
        tick();
        assert_cnt++; if (redirect_valid !== 1'b0 || {flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL rmid_idle: got v=%b fl=%b exp 0/00", redirect_valid, {flush_if, flush_id}); end
        ex_jump_req = 1; jump_addr = 16'h0900;
        tick(); ex_jump_req = 0; rst = 1;
        tick(); rst = 0; #1;
        assert_cnt++; if (redirect_valid !== 1'b0 || {flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL rconsume_suppress: got v=%b fl=%b exp 0/00", redirect_valid, {flush_if, flush_id}); end
        tick();
        $display("test_reset_mid_redir: done");
    endtask

`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
    task automatic test_delay_slot();
        ex_jump_req = 1; jump_addr = 16'h0800; pc_stall = 0;
        tick(); ex_jump_req = 0; id_is_delay_slot = 1;
        tick(); id_is_delay_slot = 0; #1;
        assert_cnt++; if ({flush_if, flush_id} !== 2'b00) begin fail_cnt++; $display("FAIL ds_flush: got %b exp 00", {flush_if, flush_id}); end
        tick();
        $display("test_delay_slot: done");
    endtask
`endif

    initial begin
        fork
            begin
                test_reset();
                test_id_jump();
                test_ex_priority();
                test_stall_override();
                test_back_to_back();
                test_reset_mid_redir();
`ifdef JUMP_REDIRECT_DELAY_SLOT_EN
                test_delay_slot();
`endif
            end
            begin
                #100000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
- Sequences the jump-address datapath mux.
- Each cycle, picks the winning redirect request: an EX-stage branch resolved by the ALU, or an ID-stage direct jump.
- Drives the mux select (jump_data_op) and latches the selected jump_addr.
- Presents the latched address to the PC stage through a valid/stall handshake and pulses the pipeline flush signals.

Parameters:
- PC_W, 16, width of PC and jump addresses; matches `PC_BUS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- ex_jump_req  input  1  EX-stage branch taken; target comes from alu_answer.
- id_jump_req  input  1  ID-stage jump; target comes from jump_answer.
- jump_addr  input  PC_W  output of the jump-data mux, fed back.
- pc_stall  input  1  PC stage cannot accept a redirect this cycle.
- jump_data_op  output  2  mux select, combinational: `JUMP_DATA_NOP / `JUMP_DATA_ALU / `JUMP_DATA_JANS.
- redirect_valid  output  1  registered; held redirect is being offered to PC.
- redirect_addr  output  PC_W  registered target address.
- flush_if  output  1  registered one-cycle pulse; kill the IF-stage instruction.
- flush_id  output  1  registered one-cycle pulse; kill the ID-stage instruction.
- busy  output  1  equals redirect_valid; upstream may use it to hold ID.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high.
- Reset values: state IDLE, redirect_valid=0, redirect_addr=0, flush_if=0, flush_id=0, held source = NONE.
- States: IDLE (nothing held) and REDIR (redirect_valid=1).
- Accept condition: a request is accepted when state==IDLE, or when state==REDIR and the held source is ID (override case, see below).
- Priority: EX wins over ID when both are asserted in the same cycle; the ID request is dropped (wrong path).
- jump_data_op, combinational:
  - ALU when an EX request is accepted this cycle.
  - JANS when an ID request is accepted this cycle.
  - NOP otherwise, including while holding.
- Capture: in the accept cycle N, jump_addr is latched into redirect_addr and the source (EX/ID) is recorded.
  - redirect_valid=1 from cycle N+1. Latency is one cycle.
- IDLE -> REDIR on any accepted request.
- Handshake:
  - The redirect is consumed in the cycle where redirect_valid=1 && pc_stall=0.
  - redirect_addr is stable while redirect_valid=1 && pc_stall=1.
- Flush on consume: the flushes are pulsed in the cycle after consume, for exactly one cycle.
  - flush_if=1 for either source.
  - flush_id=1 only when the source is EX.
- REDIR -> IDLE on consume.
- Requests in the consume cycle are dropped; they belong to wrong-path instructions being flushed.
- Override while stalled: in REDIR with pc_stall=1, if the held source is ID and ex_jump_req=1:
  - jump_data_op=ALU, redirect_addr is replaced next cycle, and the source becomes EX. The older instruction wins.
  - id_jump_req is ignored in REDIR.
  - ex_jump_req is ignored in REDIR when the held source is already EX.
- Reset mid-REDIR: discards the held redirect and suppresses any pending flush pulse.
- redirect_addr width is exactly PC_W; no truncation or extension is performed.

Optional Feature:
- Macro: JUMP_REDIRECT_DELAY_SLOT_EN.
- Defined: one branch delay slot is architected.
  - flush_if is never asserted.
  - flush_id is asserted for EX-source redirects only when the delay-slot instruction has already left ID. This is signalled by the extra input id_is_delay_slot=0; when it is 1, flush_id is suppressed.
- Not defined: the id_is_delay_slot port is absent, and the flush rules above apply unchanged.

Decomposition:
- Shared define/package holds:
  - `JUMP_DATA_NOP=2'b00, `JUMP_DATA_ALU=2'b01, `JUMP_DATA_JANS=2'b10.
  - `JUMP_DATA_BUS, `PC_BUS.
  - Source encoding SRC_NONE/SRC_ID/SRC_EX.
  - State encoding IDLE/REDIR.
- No sub-module. The state register, held-address register and flush pulse register all live in one always block set; the select logic is a small combinational block.

Test Plan:
- Reset for 2 cycles, then idle 5 cycles -> jump_data_op=NOP, redirect_valid=0, flush_if=flush_id=0 throughout.
- id_jump_req=1, jump_addr=16'h0040, pc_stall=0 at cycle N:
  - jump_data_op=JANS in N.
  - redirect_valid=1, redirect_addr=16'h0040 in N+1.
  - flush_if=1, flush_id=0 in N+2.
  - IDLE in N+2.
- ex_jump_req and id_jump_req both 1 at cycle N, jump_addr=16'h1234 -> jump_data_op=ALU; redirect_addr=16'h1234; flush_if=flush_id=1 after consume.
- ID redirect to 16'h0040 with pc_stall=1 held 3 cycles -> redirect_valid and addr stable 3 cycles; ex_jump_req with jump_addr=16'h0100 during the stall -> redirect_addr becomes 16'h0100; consume gives flush_id=1.
- rst asserted while REDIR with pc_stall=1 -> next cycle redirect_valid=0, no flush pulse, state IDLE.
- With JUMP_REDIRECT_DELAY_SLOT_EN: EX redirect with id_is_delay_slot=1 -> flush_if=0, flush_id=0 after consume.
